// File: rtl/winner_scan.sv
// winner_scan: snapshots CANDS counts on start, then compares one per clock; done pulses CANDS cycles after start.
// No backpressure: start is ignored while busy. Optional abort input via `WINNER_SCAN_ABORT_EN.
module winner_scan #(
  parameter int WIDTH = 4,
  parameter int CANDS = 4,
  parameter int IDX_W = $clog2(CANDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CANDS*WIDTH-1:0] counts,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       winner,
  output logic [WIDTH-1:0]       max_count,
  output logic                   tie
`ifdef WINNER_SCAN_ABORT_EN
  ,
  input  logic                   abort
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] snap [CANDS];
  logic [WIDTH-1:0] work_max, max_nxt;
  logic [IDX_W-1:0] work_idx, idx_nxt, ptr;
  logic             work_tie, tie_nxt;
  logic             last, abort_req;

`ifdef WINNER_SCAN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last = (ptr == IDX_W'(CANDS - 1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Strict greater-than keeps the lowest index on equal counts.
  always_comb begin
    max_nxt = work_max;
    idx_nxt = work_idx;
    tie_nxt = work_tie;
    if (snap[ptr] > work_max) begin
      max_nxt = snap[ptr];
      idx_nxt = ptr;
      tie_nxt = 1'b0;
    end else if (snap[ptr] == work_max) begin
      tie_nxt = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN: begin
        if (abort_req)  state_nxt = IDLE;
        else if (last)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CANDS; i++) snap[i] <= '0;
      work_max  <= '0;
      work_idx  <= '0;
      work_tie  <= 1'b0;
      ptr       <= '0;
      winner    <= '0;
      max_count <= '0;
      tie       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < CANDS; i++) snap[i] <= counts[i*WIDTH +: WIDTH];
            work_max <= counts[WIDTH-1:0];
            work_idx <= '0;
            work_tie <= 1'b0;
            ptr      <= IDX_W'(1);
          end
        end
        SCAN: begin
          if (!abort_req) begin
            work_max <= max_nxt;
            work_idx <= idx_nxt;
            work_tie <= tie_nxt;
            ptr      <= ptr + IDX_W'(1);
            // Results only move on the edge into DONE; an abort leaves them untouched.
            if (last) begin
              winner    <= idx_nxt;
              max_count <= max_nxt;
              tie       <= tie_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_winner_scan.sv
// Bench for winner_scan: cycle-level reference model plus directed vectors with hand-computed results.
module tb_winner_scan;
  localparam int WIDTH = 4;
  localparam int CANDS = 4;
  localparam int IDX_W = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [CANDS*WIDTH-1:0] counts;
  logic                   busy;
  logic                   done;
  logic [IDX_W-1:0]       winner;
  logic [WIDTH-1:0]       max_count;
  logic                   tie;
`ifdef WINNER_SCAN_ABORT_EN
  logic                   abort;
`endif

  winner_scan #(.WIDTH(WIDTH), .CANDS(CANDS), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .counts    (counts),
    .busy      (busy),
    .done      (done),
    .winner    (winner),
    .max_count (max_count),
    .tie       (tie)
`ifdef WINNER_SCAN_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [CANDS*WIDTH-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {WIDTH'(a3), WIDTH'(a2), WIDTH'(a1), WIDTH'(a0)};
  endfunction

  // Reference result: largest value, first index holding it, tie if it occurs more than once.
  function automatic void calc(input logic [CANDS*WIDTH-1:0] v, output int w, output int mx, output int t);
    int n;
    int c;
    mx = 0;
    w  = 0;
    n  = 0;
    for (int i = 0; i < CANDS; i++) begin
      c = int'(v[i*WIDTH +: WIDTH]);
      if (c > mx) mx = c;
    end
    for (int i = 0; i < CANDS; i++) begin
      c = int'(v[i*WIDTH +: WIDTH]);
      if (c == mx) begin
        if (n == 0) w = i;
        n++;
      end
    end
    t = (n > 1) ? 1 : 0;
  endfunction

  // Model: m_cnt counts remaining busy cycles; the cycle with m_cnt==1 is the done cycle.
  int                     m_cnt = 0;
  int                     m_win = 0;
  int                     m_max = 0;
  int                     m_tie = 0;
  bit                     m_ab  = 1'b0;
  logic [CANDS*WIDTH-1:0] m_snap = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0;
      m_win = 0;
      m_max = 0;
      m_tie = 0;
    end else if (m_cnt > 0) begin
      m_ab = 1'b0;
`ifdef WINNER_SCAN_ABORT_EN
      m_ab = abort;
`endif
      if (m_ab && m_cnt > 1) begin
        m_cnt = 0;
      end else begin
        m_cnt--;
        if (m_cnt == 1) calc(m_snap, m_win, m_max, m_tie);
      end
    end else if (start) begin
      m_snap = counts;
      m_cnt  = CANDS;
    end
  end

  always begin
    @(posedge clk);
    #1;
    check("cyc_busy", int'(busy), (m_cnt > 0) ? 1 : 0);
    check("cyc_done", int'(done), (m_cnt == 1) ? 1 : 0);
    check("cyc_winner", int'(winner), m_win);
    check("cyc_max", int'(max_count), m_max);
    check("cyc_tie", int'(tie), m_tie);
    if (done) done_cnt++;
  end

  task automatic run(input logic [CANDS*WIDTH-1:0] c);
    @(negedge clk);
    counts = c;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic expect_result(input string name, input int w, input int mx, input int t);
    check({name, "_winner"}, int'(winner), w);
    check({name, "_max"}, int'(max_count), mx);
    check({name, "_tie"}, int'(tie), t);
    check({name, "_model_winner"}, m_win, w);
    check({name, "_model_max"}, m_max, mx);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int dc;
    reset  = 1'b1;
    start  = 1'b0;
    counts = '0;
`ifdef WINNER_SCAN_ABORT_EN
    abort  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_max", int'(max_count), 0);
    check("rst_tie", int'(tie), 0);
    reset = 1'b0;

    run(pack(3, 9, 2, 7));
    wait_done(n);
    check("t1_latency", n, CANDS - 1);
    expect_result("t1", 1, 9, 0);

    run(pack(5, 2, 5, 1));
    wait_done(n);
    expect_result("t2", 0, 5, 1);

    run(pack(4, 4, 9, 1));
    wait_done(n);
    expect_result("t3", 2, 9, 0);

    run(pack(0, 0, 0, 0));
    wait_done(n);
    expect_result("t4", 0, 0, 1);

    run(pack(0, 0, 0, 15));
    wait_done(n);
    expect_result("t5", 3, 15, 0);

    // Counts change and a second start arrives mid-scan; both must be ignored.
    @(negedge clk);
    counts = pack(1, 2, 3, 4);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    counts = pack(9, 9, 9, 9);
    @(negedge clk);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dc = done_cnt;
    wait_done(n);
    expect_result("t6", 3, 4, 0);
    repeat (4) @(negedge clk);
    check("t6_single_done", done_cnt - dc, 1);

    // Reset during the second SCAN cycle.
    run(pack(3, 9, 2, 7));
    wait_done(n);
    expect_result("t7a", 1, 9, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t7_busy", int'(busy), 0);
    check("t7_done", int'(done), 0);
    check("t7_winner", int'(winner), 0);
    check("t7_max", int'(max_count), 0);
    check("t7_tie", int'(tie), 0);
    dc = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("t7_no_done", done_cnt - dc, 0);
    run(pack(2, 8, 8, 1));
    wait_done(n);
    expect_result("t7b", 1, 8, 1);

`ifdef WINNER_SCAN_ABORT_EN
    run(pack(1, 3, 6, 2));
    wait_done(n);
    expect_result("t8a", 2, 6, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    dc = done_cnt;
    @(negedge clk);
    abort = 1'b0;
    check("t8_busy", int'(busy), 0);
    check("t8_winner", int'(winner), 2);
    check("t8_max", int'(max_count), 6);
    repeat (4) @(negedge clk);
    check("t8_no_done", done_cnt - dc, 0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
